// File: rtl/bg_write_scatter.sv
// rtl/bg_write_scatter.sv - bank-group write scatter for NTT (32-lane) and MSM (4-lane) beats
module bg_write_scatter #(
  parameter int DW    = 256,
  parameter int AW    = 10,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                flag_msm,
  input  logic [AW-1:0]       base_addr,
  input  logic [CNT_W-1:0]    num_beats,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*DW-1:0]    din,
  output logic [31:0]         we,
  output logic [AW-1:0]       waddr,
  output logic [32*DW-1:0]    wdata,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2:0]        col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [31:0]       we_q, we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [32*DW-1:0]  wdata_q, wdata_d;
  logic              done_q, done_d;

  logic              accept;
  logic              last_beat;
  logic [7:0]        col_oh;
  int unsigned       col_i;

  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt_q == num_q - CNT_W'(1));
  assign col_oh    = 8'd1 << col_q;
  assign col_i     = 32'(col_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a zero-length transfer goes straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (num_beats == '0) ? S_DONE : S_RUN;
      S_RUN:  if (accept && last_beat) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q != S_IDLE);
  end

  // Datapath next values: capture transfer setup on start, scatter each accepted beat
  always_comb begin
    mode_d  = mode_q;
    addr_d  = addr_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    we_d    = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = (state_q == S_DONE);

    if (state_q == S_IDLE && start) begin
      mode_d = flag_msm;
      addr_d = base_addr;
      col_d  = '0;
      cnt_d  = '0;
      num_d  = num_beats;
    end

    if (accept) begin
      cnt_d   = cnt_q + CNT_W'(1);
      waddr_d = addr_q;
      if (!mode_q) begin
        we_d    = '1;
        wdata_d = din;
        addr_d  = addr_q + AW'(1);
      end else begin
        // Inverse of the read-side selector: lane0/1/2/3 land in quarters 0/2/1/3
        we_d = {4{col_oh}};
        wdata_d[col_i*DW        +: DW] = din[0*DW +: DW];
        wdata_d[(col_i+16)*DW   +: DW] = din[1*DW +: DW];
        wdata_d[(col_i+8)*DW    +: DW] = din[2*DW +: DW];
        wdata_d[(col_i+24)*DW   +: DW] = din[3*DW +: DW];
        col_d = col_q + 3'd1;
        if (col_q == 3'd7) addr_d = addr_q + AW'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      addr_q  <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bg_write_scatter.sv
// tb/tb_bg_write_scatter.sv - randomized self-checking bench for bg_write_scatter
module tb_bg_write_scatter;
  localparam int DW    = 256;
  localparam int AW    = 10;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              flag_msm;
  logic [AW-1:0]     base_addr;
  logic [CNT_W-1:0]  num_beats;
  logic              in_valid;
  logic              in_ready;
  logic [32*DW-1:0]  din;
  logic [31:0]       we;
  logic [AW-1:0]     waddr;
  logic [32*DW-1:0]  wdata;
  logic              busy;
  logic              done;

  bg_write_scatter #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flag_msm(flag_msm),
    .base_addr(base_addr), .num_beats(num_beats), .in_valid(in_valid),
    .in_ready(in_ready), .din(din), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bank contents as last written, plus the write expected this cycle
  logic [DW-1:0] mb [32];
  logic [31:0]   exp_we;
  int            exp_waddr;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input bit r, input bit b, input bit d);
    check("in_ready", DW'(in_ready), DW'(r));
    check("busy", DW'(busy), DW'(b));
    check("done", DW'(done), DW'(d));
    check("we", DW'(we), DW'(exp_we));
    if (exp_we != 0) check("waddr", DW'(waddr), DW'(exp_waddr));
    for (int k = 0; k < 32; k++)
      check($sformatf("wdata_bank%0d", k), wdata[k*DW +: DW], mb[k]);
  endtask

  task automatic check_reset_outputs();
    check("rst_we", DW'(we), '0);
    check("rst_waddr", DW'(waddr), '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    check("rst_in_ready", DW'(in_ready), '0);
    for (int k = 0; k < 32; k++)
      check($sformatf("rst_wdata_bank%0d", k), wdata[k*DW +: DW], '0);
  endtask

  function automatic logic [DW-1:0] rand_lane();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // pat 0: random; pat 1: lane k = k + 100*beat; pat 2: lanes 0..3 = A,B,C,D + beat
  function automatic logic [DW-1:0] gen_lane(input int pat, input int beat, input int k);
    logic [DW-1:0] base4 [4];
    base4[0] = DW'(32'hA000_0000);
    base4[1] = DW'(32'hB000_0000);
    base4[2] = DW'(32'hC000_0000);
    base4[3] = DW'(32'hD000_0000);
    if (pat == 1) return DW'(k + 100 * beat);
    if (pat == 2 && k < 4) return base4[k] + DW'(beat);
    return rand_lane();
  endfunction

  // vmode 0: valid held; 1: toggles 1,0,1,0; 2: random
  task automatic run_transfer(input bit mode, input int base, input int n, input int vmode,
                              input int pat, input int abort_at);
    int acc = 0;
    int post = -1;
    int cyc = 0;
    bit running;
    bit finished = 0;
    logic [DW-1:0] ln [32];

    @(negedge clk);
    check_outputs(1'b0, 1'b0, 1'b0);
    exp_we    = '0;
    start     = 1'b1;
    flag_msm  = mode;
    base_addr = AW'(base);
    num_beats = CNT_W'(n);
    in_valid  = 1'b0;
    if (n == 0) post = 0;

    while (cyc < 2000) begin
      @(negedge clk);
      if (post >= 0) post++;
      start   = 1'b0;
      running = (acc < n);
      check_outputs(running, running || post == 1, post == 2);
      exp_we = '0;
      if (post == 2) begin
        finished = 1;
        break;
      end
      if (abort_at >= 0 && acc == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        for (int k = 0; k < 32; k++) mb[k] = '0;
        exp_waddr = 0;
        in_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      // Starts while busy must be ignored
      if ((running || post == 1) && ($urandom % 3 == 0)) begin
        start     = 1'b1;
        flag_msm  = 1'($urandom);
        base_addr = AW'($urandom);
        num_beats = CNT_W'($urandom);
      end
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom);
      endcase
      for (int k = 0; k < 32; k++) begin
        ln[k] = gen_lane(pat, acc, k);
        din[k*DW +: DW] = ln[k];
      end
      if (running && in_valid) begin
        if (!mode) begin
          for (int k = 0; k < 32; k++) mb[k] = ln[k];
          exp_we    = 32'hFFFF_FFFF;
          exp_waddr = (base + acc) % (1 << AW);
        end else begin
          int c;
          c = acc % 8;
          mb[c]      = ln[0];
          mb[16 + c] = ln[1];
          mb[8 + c]  = ln[2];
          mb[24 + c] = ln[3];
          exp_we[c]      = 1'b1;
          exp_we[8 + c]  = 1'b1;
          exp_we[16 + c] = 1'b1;
          exp_we[24 + c] = 1'b1;
          exp_waddr = (base + acc / 8) % (1 << AW);
        end
        acc++;
        if (acc == n) post = 0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (!finished) check("timeout", DW'(1), DW'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    flag_msm  = 1'b0;
    base_addr = '0;
    num_beats = '0;
    in_valid  = 1'b0;
    din       = '0;
    exp_we    = '0;
    exp_waddr = 0;
    for (int k = 0; k < 32; k++) mb[k] = '0;

    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_transfer(1'b0, 5, 3, 0, 1, -1);
    run_transfer(1'b1, 0, 9, 0, 2, -1);
    run_transfer(1'b1, 32, 6, 1, 2, -1);
    run_transfer(1'b0, 17, 0, 0, 0, -1);
    run_transfer(1'b0, 1023, 2, 0, 1, -1);
    run_transfer(1'b1, 100, 12, 0, 2, 4);
    run_transfer(1'b1, 300, 3, 0, 2, -1);

    for (int t = 0; t < 10; t++)
      run_transfer(1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 20)),
                   2, 0, -1);

    @(negedge clk);
    check_outputs(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
